t_ff_counter: RTL

Cascadable modulo-N up/down counter whose state bits are toggle cells. Each rising clock it computes a per-bit toggle vector T = Q XOR Q_next. This is the T-input generator that sits directly upstream of the toggle flip-flop stage, packaged together with its cells. Digits chain through a combinational carry, for example decade digits of a BCD counter.

---
 rtl/t_ff_pkg.sv | 27 ++
 rtl/t_cell.sv | 28 ++
 rtl/t_ff_counter.sv | 71 +++++++
 3 files changed

// File: rtl/t_ff_pkg.sv
// -----------------------------------------------------------------------------
// t_ff_pkg
// Shared definitions for the toggle-cell modulo-N counter.
//   DIR_UP / DIR_DOWN : values of the UP input
//   cnt_t / mod_t     : widest supported count value / modulus (up to 2^32)
//   next_count()      : modulo-N successor/predecessor of a count value
// -----------------------------------------------------------------------------
package t_ff_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int MAX_WIDTH = 32;

   typedef logic [MAX_WIDTH-1:0] cnt_t;
   typedef logic [MAX_WIDTH:0]   mod_t;   // one extra bit so 2^32 fits

   // Next count value, wrapping at modulus-1 (up) or 0 (down).
   // Callers truncate the result to their own width.
   function automatic cnt_t next_count(input cnt_t q, input logic up, input mod_t modulus);
      cnt_t last;
      last = cnt_t'(modulus - mod_t'(1));
      if (up == DIR_UP) return (q == last) ? '0 : q + cnt_t'(1);
      else              return (q == '0)   ? last : q - cnt_t'(1);
   endfunction

endpackage

// File: rtl/t_cell.sv
// -----------------------------------------------------------------------------
// t_cell
// Single toggle flip-flop with asynchronous active-low clear.
//   CLK  : rising-edge clock
//   INIT : async clear, active low (Q -> 0 immediately)
//   T    : toggle enable sampled at the rising edge
//   Q    : cell state
// -----------------------------------------------------------------------------
module t_cell (
   input  logic CLK,
   input  logic INIT,
   input  logic T,
   output logic Q
);

   logic q_q;
   logic q_d;

   assign q_d = T ? ~q_q : q_q;

   always_ff @(posedge CLK or negedge INIT) begin
      if (!INIT) q_q <= 1'b0;
      else       q_q <= q_d;
   end

   assign Q = q_q;

endmodule

// File: rtl/t_ff_counter.sv
// -----------------------------------------------------------------------------
// t_ff_counter
// Cascadable modulo-MODULUS up/down counter built from toggle cells. The
// next count is computed in binary, then XORed with the current count to form
// the per-bit toggle vector that drives the cells.
//   CLK  : clock, rising edge
//   INIT : async reset, active low
//   CI   : count enable / carry in from the less-significant digit
//   UP   : direction, 1 = increment, 0 = decrement
//   LOAD : synchronous load strobe (highest priority), clamped to MODULUS-1
//   D    : load value
//   Q    : current count
//   CO   : combinational carry/borrow out, high in the cycle whose edge wraps
// -----------------------------------------------------------------------------
module t_ff_counter
   import t_ff_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             CLK,
   input  logic             INIT,
   input  logic             CI,
   input  logic             UP,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             CO
);

   if (WIDTH < 1 || WIDTH > MAX_WIDTH || MODULUS < 2 ||
       64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_param
      $fatal(1, "t_ff_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
   end

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] q_q;     // state held in the toggle cells
   logic [WIDTH-1:0] q_d;     // binary next state
   logic [WIDTH-1:0] t_vec;   // toggle vector applied to the cells

   always_comb begin
      q_d = q_q;
      if (LOAD)    q_d = (D > LAST) ? LAST : D;
      else if (CI) q_d = WIDTH'(next_count(cnt_t'(q_q), UP, mod_t'(MODULUS)));
   end

   // Only bits that differ between now and next need to toggle.
   assign t_vec = q_q ^ q_d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      t_cell u_cell (
         .CLK  (CLK),
         .INIT (INIT),
         .T    (t_vec[i]),
         .Q    (q_q[i])
      );
   end

   assign Q  = q_q;
   assign CO = CI & ~LOAD & ((UP == DIR_UP) ? (q_q == LAST) : (q_q == '0));

`ifndef SYNTHESIS
   a_in_range : assert property (@(posedge CLK) disable iff (!INIT) q_q <= LAST);

   // A carry out must be followed by the wrap value for the sampled direction.
   a_co_wraps : assert property (@(posedge CLK) disable iff (!INIT)
      CO |=> (q_q == (($past(UP) == DIR_UP) ? '0 : LAST)));
`endif

endmodule
